// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache memory-port arbiter.
// Optional round-robin policy: define CACHE_ARB_ROUND_ROBIN_EN.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 128;
  localparam int SEL_W_DEF  = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: fixed D-over-I priority by default,
// alternating on conflict when CACHE_ARB_ROUND_ROBIN_EN is defined.
module arb_pick (
  input  logic i_req_i,
  input  logic d_req_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  logic last_d_i,
`endif
  output logic i_gnt_o,
  output logic d_gnt_o
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    i_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (i_req_i && d_req_i) begin
      // On conflict the master that did not win last time goes first.
      d_gnt_o = ~last_d_i;
      i_gnt_o = last_d_i;
    end else begin
      d_gnt_o = d_req_i;
      i_gnt_o = i_req_i;
    end
`else
    d_gnt_o = d_req_i;
    i_gnt_o = i_req_i & ~d_req_i;
`endif
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave Wishbone arbiter for the line-wide memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache master
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_stb,
  input  logic              i_we,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  output logic              i_rty,
  // D-cache master
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic              d_stb,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              d_rty,
  // Memory slave
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat_m,
  output logic [SEL_W-1:0]  mem_sel,
  output logic              mem_stb,
  output logic              mem_cyc,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dat_s,
  input  logic              mem_ack
);

  arb_state_t state_q, state_d;
  logic       pick_i, pick_d;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 1 = D-cache won the most recent grant; reset to I so D wins the first conflict.
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (pick_i || pick_d)) last_d_d = pick_d;
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`endif

  arb_pick u_pick (
    .i_req_i (i_stb),
    .d_req_i (d_stb),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    .last_d_i(last_d_q),
`endif
    .i_gnt_o (pick_i),
    .d_gnt_o (pick_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_adr   = '0;
    mem_dat_m = '0;
    mem_sel   = '0;
    mem_we    = 1'b0;
    mem_stb   = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // mem_ack is ignored here; strobe stays low for the arbitration cycle.
        if (pick_d)      state_d = GRANT_D;
        else if (pick_i) state_d = GRANT_I;
      end
      GRANT_I: begin
        mem_adr   = i_adr;
        mem_dat_m = i_dat_m;
        mem_sel   = i_sel;
        mem_we    = i_we;
        mem_stb   = i_stb;
        i_ack     = mem_ack;
        // A withdrawn strobe also ends the grant; the ack is still forwarded.
        if (mem_ack || !i_stb) state_d = IDLE;
      end
      GRANT_D: begin
        mem_adr   = d_adr;
        mem_dat_m = d_dat_m;
        mem_sel   = d_sel;
        mem_we    = d_we;
        mem_stb   = d_stb;
        d_ack     = mem_ack;
        if (mem_ack || !d_stb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_cyc = mem_stb;

  // Read data is broadcast; only the per-master ack qualifies it.
  assign i_dat_s = mem_dat_s;
  assign d_dat_s = mem_dat_s;

  assign i_rty = i_stb & ~i_ack;
  assign d_rty = d_stb & ~d_ack;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level owner model. Honours CACHE_ARB_ROUND_ROBIN_EN.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_adr, d_adr, mem_adr;
  logic [DW-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s, mem_dat_m, mem_dat_s;
  logic [SW-1:0] i_sel, d_sel, mem_sel;
  logic          i_stb, i_we, i_ack, i_rty;
  logic          d_stb, d_we, d_ack, d_rty;
  logic          mem_stb, mem_cyc, mem_we, mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .i_adr    (i_adr),
    .i_dat_m  (i_dat_m),
    .i_sel    (i_sel),
    .i_stb    (i_stb),
    .i_we     (i_we),
    .i_dat_s  (i_dat_s),
    .i_ack    (i_ack),
    .i_rty    (i_rty),
    .d_adr    (d_adr),
    .d_dat_m  (d_dat_m),
    .d_sel    (d_sel),
    .d_stb    (d_stb),
    .d_we     (d_we),
    .d_dat_s  (d_dat_s),
    .d_ack    (d_ack),
    .d_rty    (d_rty),
    .mem_adr  (mem_adr),
    .mem_dat_m(mem_dat_m),
    .mem_sel  (mem_sel),
    .mem_stb  (mem_stb),
    .mem_cyc  (mem_cyc),
    .mem_we   (mem_we),
    .mem_dat_s(mem_dat_s),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory port (0 none, 1 I-cache, 2 D-cache)
  // and whether D won the last grant.
  int m_owner  = 0;
  bit m_last_d = 1'b0;

  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat_m;
  logic [SW-1:0] e_sel;
  logic          e_we, e_stb, e_i_ack, e_d_ack, e_i_rty, e_d_rty;

  always_comb begin
    e_adr = '0; e_dat_m = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0;
    e_i_ack = 1'b0; e_d_ack = 1'b0;
    if (m_owner == 1) begin
      e_adr = i_adr; e_dat_m = i_dat_m; e_sel = i_sel; e_we = i_we; e_stb = i_stb;
      e_i_ack = mem_ack;
    end else if (m_owner == 2) begin
      e_adr = d_adr; e_dat_m = d_dat_m; e_sel = d_sel; e_we = d_we; e_stb = d_stb;
      e_d_ack = mem_ack;
    end
    e_i_rty = i_stb & ~e_i_ack;
    e_d_rty = d_stb & ~e_d_ack;
  end

  // Advance one clock and apply the ownership rules to the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_owner  = 0;
      m_last_d = 1'b0;
    end else if (m_owner == 0) begin
      if (i_stb && d_stb) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        m_owner = m_last_d ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (d_stb) m_owner = 2;
      else if (i_stb)     m_owner = 1;
      if (m_owner != 0) m_last_d = (m_owner == 2);
    end else if (mem_ack || (m_owner == 1 ? !i_stb : !d_stb)) begin
      m_owner = 0;
    end
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1; i_stb = 1'b1;
    step(); step();
    #2;
    n_cmp++;
    if ({mem_stb, mem_cyc, mem_we, i_ack, d_ack} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_stb, mem_cyc, mem_we, i_ack, d_ack});
    end
    n_cmp++;
    if (mem_adr !== '0 || mem_sel !== '0 || mem_dat_m !== '0) begin
      n_err++; $display("FAIL reset_mux: got adr=%h sel=%h expected zeros", mem_adr, mem_sel);
    end
    n_cmp++;
    if (i_rty !== 1'b1) begin
      n_err++; $display("FAIL reset_rty: got %b expected 1", i_rty);
    end
    i_stb = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] line;
    line = rnd_line();
    i_adr = 32'h0000_1040; i_we = 1'b0; i_sel = '1; i_dat_m = rnd_line(); i_stb = 1'b1;
    #2;
    n_cmp++;
    if (mem_stb !== 1'b0 || i_rty !== 1'b1) begin
      n_err++; $display("FAIL rd_arb_cycle: got stb=%b rty=%b expected stb=0 rty=1", mem_stb, i_rty);
    end
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1 || mem_cyc !== 1'b1 || mem_adr !== 32'h1040 || mem_we !== 1'b0 || mem_sel !== 16'hffff) begin
      n_err++; $display("FAIL rd_grant: got stb=%b adr=%h we=%b sel=%h expected 1/00001040/0/ffff", mem_stb, mem_adr, mem_we, mem_sel);
    end
    step(); step();
    mem_ack = 1'b1; mem_dat_s = line;
    #2;
    n_cmp++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rty !== 1'b0 || i_dat_s !== line) begin
      n_err++; $display("FAIL rd_ack: got i_ack=%b d_ack=%b i_rty=%b data=%h expected 1/0/0/%h", i_ack, d_ack, i_rty, i_dat_s, line);
    end
    step();
    i_stb = 1'b0; mem_ack = 1'b0;
    #2;
    n_cmp++;
    if (mem_stb !== 1'b0 || i_ack !== 1'b0) begin
      n_err++; $display("FAIL rd_release: got stb=%b ack=%b expected 0/0", mem_stb, i_ack);
    end
    step();
  endtask

  task automatic test_simultaneous();
    i_adr = 32'h0000_3000; i_we = 1'b0;
    d_adr = 32'h0000_2000; d_we = 1'b1; d_dat_m = rnd_line(); d_sel = 16'h00ff;
    i_stb = 1'b1; d_stb = 1'b1;
    step(); #2;
    n_cmp++;
    if (mem_adr !== 32'h2000 || mem_we !== 1'b1 || mem_dat_m !== d_dat_m || i_rty !== 1'b1) begin
      n_err++; $display("FAIL sim_grant_d: got adr=%h we=%b i_rty=%b expected 00002000/1/1", mem_adr, mem_we, i_rty);
    end
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || i_rty !== 1'b1) begin
      n_err++; $display("FAIL sim_ack_d: got d_ack=%b i_ack=%b i_rty=%b expected 1/0/1", d_ack, i_ack, i_rty);
    end
    step();
    d_stb = 1'b0; mem_ack = 1'b0;
    #2;
    n_cmp++;
    if (mem_stb !== 1'b0 || i_rty !== 1'b1) begin
      n_err++; $display("FAIL sim_turnaround: got stb=%b i_rty=%b expected 0/1", mem_stb, i_rty);
    end
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1 || mem_adr !== 32'h3000 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL sim_grant_i: got stb=%b adr=%h we=%b expected 1/00003000/0", mem_stb, mem_adr, mem_we);
    end
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
      n_err++; $display("FAIL sim_ack_i: got i_ack=%b d_ack=%b expected 1/0", i_ack, d_ack);
    end
    step();
    i_stb = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_grant_order();
    int exp_d, got_d;
    i_adr = 32'h0000_3000; d_adr = 32'h0000_2000; i_we = 1'b0; d_we = 1'b0;
    i_stb = 1'b1; d_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      if (mem_stb !== 1'b0) begin
        n_err++; $display("FAIL order_idle%0d: got stb=%b expected 0", k, mem_stb);
      end
      step(); #2;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0) ? 1 : 0;
`else
      exp_d = 1;
`endif
      got_d = (mem_adr === 32'h2000) ? 1 : 0;
      n_cmp++;
      if (mem_stb !== 1'b1 || got_d != exp_d) begin
        n_err++; $display("FAIL order_grant%0d: got stb=%b d_granted=%0d expected 1/%0d", k, mem_stb, got_d, exp_d);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    i_stb = 1'b0; d_stb = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    i_adr = 32'h0000_1040; i_stb = 1'b1;
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1) begin
      n_err++; $display("FAIL rstmid_grant: got stb=%b expected 1", mem_stb);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    n_cmp++;
    if (mem_stb !== 1'b0 || i_rty !== 1'b1) begin
      n_err++; $display("FAIL rstmid_idle: got stb=%b i_rty=%b expected 0/1", mem_stb, i_rty);
    end
    i_stb = 1'b0;
    step();
    mem_ack = 1'b1;
    #2;
    n_cmp++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_stb !== 1'b0) begin
      n_err++; $display("FAIL rstmid_late_ack: got i_ack=%b d_ack=%b stb=%b expected 0/0/0", i_ack, d_ack, mem_stb);
    end
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_withdraw();
    i_adr = 32'h0000_3000; d_adr = 32'h0000_2000;
    i_stb = 1'b1; d_stb = 1'b1;
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1 || mem_adr !== 32'h2000) begin
      n_err++; $display("FAIL wd_grant_d: got stb=%b adr=%h expected 1/00002000", mem_stb, mem_adr);
    end
    d_stb = 1'b0;
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b0 || i_rty !== 1'b1 || d_ack !== 1'b0) begin
      n_err++; $display("FAIL wd_idle: got stb=%b i_rty=%b d_ack=%b expected 0/1/0", mem_stb, i_rty, d_ack);
    end
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1 || mem_adr !== 32'h3000) begin
      n_err++; $display("FAIL wd_grant_i: got stb=%b adr=%h expected 1/00003000", mem_stb, mem_adr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; i_stb = 1'b0;
    step();
  endtask

  task automatic test_idle_ack();
    i_stb = 1'b0; d_stb = 1'b0; mem_ack = 1'b1;
    #2;
    n_cmp++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_stb !== 1'b0) begin
      n_err++; $display("FAIL idle_ack: got i_ack=%b d_ack=%b stb=%b expected 0/0/0", i_ack, d_ack, mem_stb);
    end
    step();
    mem_ack = 1'b0; d_adr = 32'h0000_2000; d_stb = 1'b1;
    #2;
    n_cmp++;
    if (mem_stb !== 1'b0) begin
      n_err++; $display("FAIL idle_ack_state: got stb=%b expected 0", mem_stb);
    end
    step(); #2;
    n_cmp++;
    if (mem_stb !== 1'b1 || mem_adr !== 32'h2000) begin
      n_err++; $display("FAIL idle_ack_grant: got stb=%b adr=%h expected 1/00002000", mem_stb, mem_adr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; d_stb = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic prev_i_ack, prev_d_ack;
    prev_i_ack = 1'b0; prev_d_ack = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (i_stb && !prev_i_ack) i_stb = ($urandom_range(0, 19) != 0);
      else begin
        i_stb = ($urandom_range(0, 1) == 1);
        i_adr = {$urandom_range(0, 65535), 4'h0} ; i_we = $urandom_range(0, 1);
        i_sel = $urandom; i_dat_m = rnd_line();
      end
      if (d_stb && !prev_d_ack) d_stb = ($urandom_range(0, 19) != 0);
      else begin
        d_stb = ($urandom_range(0, 1) == 1);
        d_adr = {$urandom_range(0, 65535), 4'h0}; d_we = $urandom_range(0, 1);
        d_sel = $urandom; d_dat_m = rnd_line();
      end
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_dat_s = rnd_line();
      #2;
      n_cmp++;
      if ({mem_adr, mem_dat_m, mem_sel, mem_we, mem_stb, mem_cyc} !== {e_adr, e_dat_m, e_sel, e_we, e_stb, e_stb}) begin
        n_err++; $display("FAIL rnd_mem@%0d: got adr=%h we=%b stb=%b cyc=%b expected adr=%h we=%b stb=%b", c, mem_adr, mem_we, mem_stb, mem_cyc, e_adr, e_we, e_stb);
      end
      n_cmp++;
      if ({i_ack, d_ack, i_rty, d_rty} !== {e_i_ack, e_d_ack, e_i_rty, e_d_rty}) begin
        n_err++; $display("FAIL rnd_hs@%0d: got ack i/d=%b%b rty i/d=%b%b expected %b%b %b%b", c, i_ack, d_ack, i_rty, d_rty, e_i_ack, e_d_ack, e_i_rty, e_d_rty);
      end
      n_cmp++;
      if (i_dat_s !== mem_dat_s || d_dat_s !== mem_dat_s) begin
        n_err++; $display("FAIL rnd_rdata@%0d: got i=%h d=%h expected %h", c, i_dat_s, d_dat_s, mem_dat_s);
      end
      prev_i_ack = e_i_ack | rst;
      prev_d_ack = e_d_ack | rst;
      step();
    end
    rst = 1'b0; i_stb = 1'b0; d_stb = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    i_adr = '0; i_dat_m = '0; i_sel = '0; i_stb = 1'b0; i_we = 1'b0;
    d_adr = '0; d_dat_m = '0; d_sel = '0; d_stb = 1'b0; d_we = 1'b0;
    mem_dat_s = '0; mem_ack = 1'b0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_grant_order();
    test_reset_mid();
    test_withdraw();
    test_idle_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single 128-bit physical-memory Wishbone port between the instruction-cache and data-cache memory-side masters.
- Sits between each cache's mem master port and the memory model/L2.
- Grants one master at a time and holds the grant for a whole transaction, from STB until ACK.
- Routes ACK back to the granted master only, and signals RTY to the waiting master.

Parameters:
- ADDR_W, 32, memory address width (line-aligned byte address, passed through unchanged).
- DATA_W, 128, line width in bits.
- SEL_W, DATA_W/8, byte-select width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i_adr  in  ADDR_W  I-cache request address.
- i_dat_m  in  DATA_W  I-cache write data.
- i_sel  in  SEL_W  I-cache byte selects.
- i_stb  in  1  I-cache request strobe.
- i_we  in  1  I-cache write enable (0 = read, 1 = write).
- i_dat_s  out  DATA_W  read data to I-cache.
- i_ack  out  1  I-cache transaction complete.
- i_rty  out  1  I-cache request pending, not granted.
- d_adr, d_dat_m, d_sel, d_stb, d_we, d_dat_s, d_ack, d_rty: same as the i_ set, for the D-cache.
- mem_adr  out  ADDR_W  address to memory.
- mem_dat_m  out  DATA_W  write data to memory.
- mem_sel  out  SEL_W  byte selects to memory.
- mem_stb  out  1  memory strobe.
- mem_cyc  out  1  equals mem_stb.
- mem_we  out  1  memory write enable.
- mem_dat_s  in  DATA_W  memory read data.
- mem_ack  in  1  memory transaction complete.

Behaviour:
- Clocking: one clock (clk). Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- State register: IDLE, GRANT_I, GRANT_D. Reset state is IDLE.
- Reset values of outputs: mem_stb = mem_cyc = mem_we = 0; mem_adr, mem_dat_m, mem_sel = 0; i_ack = d_ack = 0.
- i_rty/d_rty: purely combinational, so they may assert in the reset cycle if the corresponding STB is high.
- IDLE:
  - d_stb = 1 → GRANT_D (D-cache has fixed priority).
  - else i_stb = 1 → GRANT_I.
  - else stay in IDLE.
  - mem_stb = 0 while in IDLE, giving 1 cycle of arbitration latency from STB to mem_stb.
- GRANT_x:
  - mem_adr/dat_m/sel/we/stb are driven combinationally from master x.
  - mem_cyc = mem_stb.
  - x_ack = mem_ack.
  - The other master's ack = 0.
- Exit from GRANT_x:
  - On mem_ack = 1 → IDLE next cycle. There is one mandatory idle turnaround cycle between transactions; no back-to-back grant.
  - Master x drops x_stb before ACK (protocol violation) → IDLE next cycle; any mem_ack in that same cycle is still forwarded to x.
- Read data: i_dat_s = d_dat_s = mem_dat_s (broadcast). Only the ACK qualifies it.
- RTY: x_rty = x_stb & ~x_ack, i.e. asserted whenever a request is not being completed this cycle, including while granted and waiting.
- Muxed outputs outside GRANT states: mem_adr/dat_m/sel are 0; mem_we = 0.
- Both masters requesting in IDLE: D granted. I keeps i_rty = 1 and is granted after D's ACK plus the turnaround cycle, provided D does not re-request in that idle cycle.
- Reset mid-transaction: state → IDLE on the next edge; mem_stb = 0 from that cycle. A late mem_ack arriving in IDLE is ignored (no x_ack).
- mem_ack in IDLE: ignored.
- Grant duration is unbounded; the memory must eventually ACK.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last_grant register (reset = I, so D wins the first conflict).
  - When both STBs are high in IDLE, the master not granted last wins.
  - A single requester is always granted.
  - last_grant updates on entry to GRANT_x.
- Undefined: fixed D-over-I priority as described under Behaviour; no last_grant register.

Decomposition:
- Shared package cache_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT_I, GRANT_D}.
  - localparam defaults for ADDR_W, DATA_W and SEL_W.
- Sub-module arb_pick (combinational):
  - Inputs: two requests, plus last_grant when the feature is enabled.
  - Outputs: one-hot grant.
  - Keeps the priority policy separate from the state machine and muxing.

Test Plan:
- Single I read: i_stb = 1, i_adr = 0x0000_1040, mem_ack on the 3rd cycle of mem_stb → mem_stb rises 1 cycle after i_stb; mem_adr = 0x1040; i_ack pulses with mem_ack; i_dat_s = mem_dat_s; d_ack stays 0.
- Simultaneous requests: i_stb = d_stb = 1 in the same cycle, d_we = 1, d_adr = 0x2000 → GRANT_D first (mem_we = 1, mem_adr = 0x2000); i_rty = 1 throughout; after D's ACK, 1 IDLE cycle, then mem_adr = i_adr.
- Round-robin (macro defined): both masters request continuously for 4 transactions → grants in order D, I, D, I. Without the macro → D, D, D, D.
- Reset mid-transaction: rst = 1 while in GRANT_I before ACK → next cycle mem_stb = 0, state IDLE; a mem_ack arriving 2 cycles later produces no i_ack or d_ack.
- STB withdrawal: D granted, d_stb drops before ACK → next cycle mem_stb = 0 and state IDLE; a pending i_stb is granted the following cycle.
- Idle ACK: mem_ack = 1 with no grant → i_ack = d_ack = 0; state stays IDLE.
